// File: rtl/vga_scene_compositor.sv
// vga_scene_compositor
// Pixel compositor between the VGA timing generator and the VGA pins. Draws NUM_OBJ
// rectangles plus a one-scanline ground line, with fixed priority (lowest index on top)
// and a per-object hit-flash. Colour and syncs share a matched 2-stage pipeline.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   pix_en              pixel strobe; all pixel state advances only when high
//   hcount, vcount      current pixel position
//   visible             active-video flag
//   hsync_in, vsync_in  syncs from the timing generator (active low)
//   frame_tick          high on the pixel at (0,0); latches object inputs
//   obj_x/obj_y         object i position at [i*COORD_W +: COORD_W]
//   obj_rgb, obj_en     object i colour {r,g,b} and draw enable
//   flash_trig          per-object pulse that starts/restarts the flash
//   hsync, vsync        syncs delayed by 2 pixel strobes
//   vga_r/g/b           output colour
module vga_scene_compositor #(
    parameter int unsigned NUM_OBJ      = 2,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned BOX_W        = 32,
    parameter int unsigned BOX_H        = 48,
    parameter int unsigned GROUND_Y     = 430,
    parameter logic [11:0] GROUND_RGB   = 12'hFF0,
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pix_en,
    input  logic [COORD_W-1:0]         hcount,
    input  logic [COORD_W-1:0]         vcount,
    input  logic                       visible,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       frame_tick,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ*12-1:0]      obj_rgb,
    input  logic [NUM_OBJ-1:0]         obj_en,
    input  logic [NUM_OBJ-1:0]         flash_trig,
    output logic                       hsync,
    output logic                       vsync,
    output logic [3:0]                 vga_r,
    output logic [3:0]                 vga_g,
    output logic [3:0]                 vga_b
);

    localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned SUM_W = COORD_W + 1;

    logic [COORD_W-1:0] act_x   [NUM_OBJ];
    logic [COORD_W-1:0] act_y   [NUM_OBJ];
    logic [11:0]        act_rgb [NUM_OBJ];
    logic [NUM_OBJ-1:0] act_en;

    logic [NUM_OBJ-1:0] pend;
    logic [CNT_W-1:0]   cnt [NUM_OBJ];

    logic [NUM_OBJ-1:0] hit;
    logic [NUM_OBJ-1:0] hit_d;
    logic               gnd_d;
    logic               visible_d;
    logic               hsync_d;
    logic               vsync_d;
    logic [11:0]        pix_rgb;

    logic [SUM_W-1:0] h_ext;
    logic [SUM_W-1:0] v_ext;
    assign h_ext = SUM_W'(hcount);
    assign v_ext = SUM_W'(vcount);

    // Frame latch: object inputs only become visible at a frame boundary (no tearing).
    always_ff @(posedge clk) begin
        if (reset) begin
            act_en <= '0;
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                act_x[i]   <= '0;
                act_y[i]   <= '0;
                act_rgb[i] <= '0;
            end
        end else if (pix_en && frame_tick) begin
            act_en <= obj_en;
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                act_x[i]   <= obj_x[i*COORD_W +: COORD_W];
                act_y[i]   <= obj_y[i*COORD_W +: COORD_W];
                act_rgb[i] <= obj_rgb[i*12 +: 12];
            end
        end
    end

    // Flash: triggers are caught on any clk and applied on the next pixel strobe.
    // A pending load takes precedence over the per-frame decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            pend <= flash_trig | (pend & {NUM_OBJ{~pix_en}});
            if (pix_en) begin
                for (int i = 0; i < int'(NUM_OBJ); i++) begin
                    if (pend[i]) begin
                        cnt[i] <= CNT_W'(FLASH_FRAMES);
                    end else if (frame_tick && cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Bounds are widened by one bit so x+BOX_W never wraps back onto low columns.
    for (genvar i = 0; i < int'(NUM_OBJ); i++) begin : g_hit
        logic [SUM_W-1:0] x_lo;
        logic [SUM_W-1:0] y_lo;
        logic [SUM_W-1:0] x_hi;
        logic [SUM_W-1:0] y_hi;
        assign x_lo   = SUM_W'(act_x[i]);
        assign y_lo   = SUM_W'(act_y[i]);
        assign x_hi   = x_lo + SUM_W'(BOX_W);
        assign y_hi   = y_lo + SUM_W'(BOX_H);
        assign hit[i] = act_en[i] && (h_ext >= x_lo) && (h_ext < x_hi) &&
                        (v_ext >= y_lo) && (v_ext < y_hi);
    end

    // Stage 1
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_d     <= '0;
            gnd_d     <= 1'b0;
            visible_d <= 1'b0;
            hsync_d   <= 1'b1;
            vsync_d   <= 1'b1;
        end else if (pix_en) begin
            hit_d     <= hit;
            gnd_d     <= (vcount == COORD_W'(GROUND_Y));
            visible_d <= visible;
            hsync_d   <= hsync_in;
            vsync_d   <= vsync_in;
        end
    end

    // Walk from highest to lowest index so the lowest-index hit is the last writer.
    // cnt odd implies nonzero, so bit 0 alone selects the white flash phase.
    always_comb begin
        pix_rgb = gnd_d ? GROUND_RGB : BG_RGB;
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                pix_rgb = cnt[i][0] ? 12'hFFF : act_rgb[i];
            end
        end
        if (!visible_d) begin
            pix_rgb = 12'h000;
        end
    end

    // Stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            vga_r <= pix_rgb[11:8];
            vga_g <= pix_rgb[7:4];
            vga_b <= pix_rgb[3:0];
            hsync <= hsync_d;
            vsync <= vsync_d;
        end
    end

endmodule

// File: doc/vga_scene_compositor.md
Name: vga_scene_compositor

Overview:
Parametrised pixel compositor that sits between the VGA timing generator and the VGA pins. It replaces hand-drawn single-box logic with NUM_OBJ rectangular objects plus a ground line. Object positions are latched per frame to avoid tearing. Overlaps resolve by fixed priority, and each object has a per-object hit-flash effect. All colour and sync outputs leave through a matched 2-stage pixel pipeline.

Parameters:
NUM_OBJ, 2, number of rectangular objects (players/projectiles)
COORD_W, 10, width of hcount/vcount and object coordinates
BOX_W, 32, object width in pixels
BOX_H, 48, object height in pixels
GROUND_Y, 430, scanline of the 1-pixel ground line
GROUND_RGB, 12'hFF0, ground colour {r,g,b}
BG_RGB, 12'h000, background colour
FLASH_FRAMES, 8, frames an object flashes after a trigger (>=1)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
pix_en  in  1  pixel strobe; all state advances only when high, except flash_trig capture
hcount  in  COORD_W  current pixel column from timing generator
vcount  in  COORD_W  current scanline
visible  in  1  active-video flag
hsync_in  in  1  horizontal sync from timing generator (active low)
vsync_in  in  1  vertical sync from timing generator (active low)
frame_tick  in  1  high for the pixel where hcount==0 && vcount==0
obj_x  in  NUM_OBJ*COORD_W  object i left edge at bits [i*COORD_W +: COORD_W]
obj_y  in  NUM_OBJ*COORD_W  object i top edge
obj_rgb  in  NUM_OBJ*12  object i colour {r[3:0],g[3:0],b[3:0]}
obj_en  in  NUM_OBJ  object i drawn when 1
flash_trig  in  NUM_OBJ  1-clk pulse per object; starts or restarts the flash
hsync  out  1  hsync_in delayed 2 pix_en strobes
vsync  out  1  vsync_in delayed 2 pix_en strobes
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue

Behaviour:
- Reset values: vga_r/g/b=0; hsync=vsync=1 (inactive); all pipeline regs cleared, with the sync stages set to 1; active obj_en copy=0 (nothing drawn); flash counters=0; pending-trigger flags=0.
- Frame latch:
  - On a clk cycle with pix_en && frame_tick, copy obj_x/obj_y/obj_rgb/obj_en into active registers.
  - Input changes at any other time are invisible until the next frame_tick.
- Stage 1 (pix_en):
  - hit[i] = act_en[i] && hcount>=x_i && hcount<x_i+BOX_W && vcount>=y_i && vcount<y_i+BOX_H.
  - Sums are computed COORD_W+1 bits wide, so no wrap occurs. Objects extending past 639/479 clip naturally; x_i>=640 draws nothing.
  - gnd = (vcount==GROUND_Y).
  - Register hit vector, gnd, visible, hsync_in, vsync_in.
- Stage 2 (pix_en), colour selection:
  - !visible_d gives 0.
  - Otherwise the lowest-index object with a hit wins.
  - No hit and gnd_d gives GROUND_RGB.
  - Else BG_RGB.
  - Register the result onto vga_*, and register the delayed syncs onto hsync/vsync.
- Latency:
  - Exactly 2 pix_en strobes from input pixel to output, identical for colour and both syncs.
  - pix_en low: every register holds.
- Flash:
  - flash_trig[i] is sampled on any clk cycle into pend[i].
  - On the next pix_en cycle, pend[i] loads cnt[i]=FLASH_FRAMES and clears.
  - On pix_en && frame_tick, cnt[i] decrements if nonzero.
  - Trigger and decrement in the same cycle: load wins, no decrement.
  - Retrigger while flashing reloads FLASH_FRAMES.
  - While cnt[i]!=0 && cnt[i][0]==1, object i renders 12'hFFF instead of its colour. Priority is unchanged.
- Mid-frame reset: outputs go to reset values on the next clk edge. Nothing is drawn until the first frame_tick after reset.

Test Plan:
- Reset, then one frame with obj0 at (100,200), en=1, rgb=F20 -> frame 1 all black/ground-only; frame 2 pixel (100,200) emerges F20 exactly 2 pix_en later; (131,247)=F20; (132,200) and (100,248)=BG.
- Change obj_x from 100 to 300 at scanline 240 mid-frame -> rest of frame still drawn at 100; next frame at 300, no tear.
- obj0 (100,200) and obj1 (110,210), different colours -> overlap pixel (115,215) shows obj0 colour; with obj_en[0]=0 next frame it shows obj1 colour.
- Ground line: scanline 430 outside objects = FF0; an object covering y=430 overrides ground; hcount outside visible -> 0.
- obj0 at x=620 -> pixels 620..639 drawn, no wrap onto column 0..11; x=700 -> nothing drawn.
- flash_trig[0] pulse with FLASH_FRAMES=8 -> cnt 8; alternating frames FFF/F20 over 8 frames, then steady F20. Trigger coincident with frame_tick -> cnt=8, not 7. Hsync/vsync track input with 2-strobe delay throughout, with pix_en gapped 1-in-4.
